// File: rtl/blinds_pkg.sv
// Shared definitions for the roller-blinds position controller.
// Contents: level encoding (also the a/b select code seen by the output mux),
// level type and controller state enum.
package blinds_pkg;

  typedef logic [1:0] level_t;

  localparam level_t LVL_CLOSED  = 2'd0;
  localparam level_t LVL_QUARTER = 2'd1;
  localparam level_t LVL_HALF    = 2'd2;
  localparam level_t LVL_OPEN    = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown,
    StFault
  } state_e;

endpackage

// File: rtl/blinds_ctrl_if.sv
// Signal bundle between the requester/motor-driver side and blinds_ctrl.
// master: drives req_valid, req_level, step, fault_clr (and stop when built with
//         BLINDS_STOP_EN); observes req_ready, motor_up/down, a, b, busy, fault.
// slave : the controller, the mirror image of master.
interface blinds_ctrl_if;
  import blinds_pkg::*;

  logic   req_valid;
  level_t req_level;
  logic   req_ready;
  logic   step;
  logic   fault_clr;
`ifdef BLINDS_STOP_EN
  logic   stop;
`endif
  logic   motor_up;
  logic   motor_down;
  logic   a;
  logic   b;
  logic   busy;
  logic   fault;

  modport master (
    output req_valid, req_level, step, fault_clr,
`ifdef BLINDS_STOP_EN
    output stop,
`endif
    input  req_ready, motor_up, motor_down, a, b, busy, fault
  );

  modport slave (
    input  req_valid, req_level, step, fault_clr,
`ifdef BLINDS_STOP_EN
    input  stop,
`endif
    output req_ready, motor_up, motor_down, a, b, busy, fault
  );

endinterface

// File: rtl/blinds_step_tracker.sv
// Encoder step counter and inter-step watchdog for blinds_ctrl.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   active_i        motor is moving (UP or DOWN); counters frozen otherwise
//   start_i         entering a move: clears the watchdog
//   clr_i           fault cleared: step position discarded
//   step_i          one-cycle encoder pulse
//   level_tick_o    this step completes a level
//   timeout_o       watchdog expires this cycle (no step)
module blinds_step_tracker #(
  parameter int unsigned STEPS_PER_LEVEL = 16,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic start_i,
  input  logic clr_i,
  input  logic step_i,
  output logic level_tick_o,
  output logic timeout_o
);

  localparam int unsigned StepW = $clog2(STEPS_PER_LEVEL);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
  localparam logic [StepW-1:0] StepMax = StepW'(STEPS_PER_LEVEL - 1);
  localparam logic [TmoW-1:0]  TmoMax  = TmoW'(TIMEOUT - 1);

  logic [StepW-1:0] step_cnt_q, step_cnt_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;

  assign level_tick_o = active_i && step_i && (step_cnt_q == StepMax);
  assign timeout_o    = active_i && !step_i && (tmo_cnt_q == TmoMax);

  always_comb begin
    step_cnt_d = step_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (clr_i) begin
      step_cnt_d = '0;
    end else if (active_i && step_i) begin
      step_cnt_d = level_tick_o ? '0 : step_cnt_q + 1'b1;
    end
    if (start_i) begin
      tmo_cnt_d = '0;
    end else if (active_i) begin
      // On expiry this reaches TIMEOUT, which still fits; the FSM leaves the
      // moving states in the same cycle so it stops counting there.
      tmo_cnt_d = step_i ? '0 : tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

endmodule

// File: rtl/blinds_ctrl.sv
// Roller-blinds position controller. Accepts a requested level (0..3), drives
// the motor up/down counting encoder steps, and presents the current level as
// the a/b mux select (00 closed .. 11 open). A missing step for TIMEOUT cycles
// while moving raises fault until fault_clr.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         blinds_ctrl_if.slave: request handshake, step, fault_clr,
//               motor_up/down, a/b level select, busy, fault
// Build option: define BLINDS_STOP_EN to add bus.stop, which ends the current
// move at the next level boundary in the direction of travel.
module blinds_ctrl
  import blinds_pkg::*;
#(
  parameter int unsigned STEPS_PER_LEVEL = 16,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  blinds_ctrl_if.slave  bus
);

  state_e state_q, state_d;
  level_t level_q, level_d;
  level_t target_q, target_d;
  level_t target_eff;
  logic   motor_up_q, motor_down_q, busy_q, fault_q, req_ready_q;
  logic   accept, moving;
  logic   trk_start, trk_clr, level_tick, timeout;

  assign moving = (state_q == StUp) || (state_q == StDown);
  assign accept = bus.req_valid && req_ready_q;

  blinds_step_tracker #(
    .STEPS_PER_LEVEL (STEPS_PER_LEVEL),
    .TIMEOUT         (TIMEOUT)
  ) u_step_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .active_i     (moving),
    .start_i      (trk_start),
    .clr_i        (trk_clr),
    .step_i       (bus.step),
    .level_tick_o (level_tick),
    .timeout_o    (timeout)
  );

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    target_d   = target_q;
    target_eff = target_q;
    trk_start  = 1'b0;
    trk_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.req_level > level_q) begin
            target_d  = bus.req_level;
            state_d   = StUp;
            trk_start = 1'b1;
          end else if (bus.req_level < level_q) begin
            target_d  = bus.req_level;
            state_d   = StDown;
            trk_start = 1'b1;
          end
        end
      end
      StUp: begin
`ifdef BLINDS_STOP_EN
        if (bus.stop && (level_q != LVL_OPEN)) begin
          target_eff = level_q + 2'd1;
          target_d   = target_eff;
        end
`endif
        // Already at the top: nothing to drive, drop back without moving.
        if (level_q == LVL_OPEN) begin
          state_d = StIdle;
        end else if (timeout) begin
          state_d = StFault;
        end else if (level_tick) begin
          level_d = level_q + 2'd1;
          if (level_d == target_eff) state_d = StIdle;
        end
      end
      StDown: begin
`ifdef BLINDS_STOP_EN
        if (bus.stop && (level_q != LVL_CLOSED)) begin
          target_eff = level_q - 2'd1;
          target_d   = target_eff;
        end
`endif
        if (level_q == LVL_CLOSED) begin
          state_d = StIdle;
        end else if (timeout) begin
          state_d = StFault;
        end else if (level_tick) begin
          level_d = level_q - 2'd1;
          if (level_d == target_eff) state_d = StIdle;
        end
      end
      StFault: begin
        // Position is re-trusted at the last completed level.
        if (bus.fault_clr) begin
          state_d = StIdle;
          trk_clr = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      level_q      <= LVL_CLOSED;
      target_q     <= LVL_CLOSED;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      req_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      target_q     <= target_d;
      motor_up_q   <= (state_d == StUp);
      motor_down_q <= (state_d == StDown);
      busy_q       <= (state_d == StUp) || (state_d == StDown);
      fault_q      <= (state_d == StFault);
      req_ready_q  <= (state_d == StIdle);
    end
  end

  assign bus.motor_up   = motor_up_q;
  assign bus.motor_down = motor_down_q;
  assign bus.busy       = busy_q;
  assign bus.fault      = fault_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.a          = level_q[1];
  assign bus.b          = level_q[0];

endmodule

// File: tb/tb_blinds_ctrl.sv
// Directed bench for blinds_ctrl (STEPS_PER_LEVEL=16, TIMEOUT=255).
// obs packs {motor_up, motor_down, busy, fault, req_ready, a, b}.
module tb_blinds_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [6:0] obs;

  blinds_ctrl_if bus ();

  blinds_ctrl #(
    .STEPS_PER_LEVEL (16),
    .TIMEOUT         (255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign obs = {bus.motor_up, bus.motor_down, bus.busy, bus.fault, bus.req_ready, bus.a, bus.b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n encoder pulses, one every 4 cycles
  task automatic pulse_steps(input int n);
    for (int i = 0; i < n; i++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic request(input logic [1:0] lvl);
    bus.req_valid = 1'b1;
    bus.req_level = lvl;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_hold got %b exp %b", obs, 7'b0000000);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 7'b0000100) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", obs, 7'b0000100);
    end
  endtask

  task automatic test_up_0_to_2();
    request(2'd2);
    checks++;
    if (obs !== 7'b1010000) begin
      errors++;
      $display("FAIL up_accept got %b exp %b", obs, 7'b1010000);
    end
    pulse_steps(15);
    checks++;
    if (obs !== 7'b1010000) begin
      errors++;
      $display("FAIL up_step15 got %b exp %b", obs, 7'b1010000);
    end
    pulse_steps(1);
    checks++;
    if (obs !== 7'b1010001) begin
      errors++;
      $display("FAIL up_step16 got %b exp %b", obs, 7'b1010001);
    end
    pulse_steps(15);
    bus.step = 1'b1;
    checks++;
    if (obs !== 7'b1010001) begin
      errors++;
      $display("FAIL up_step31 got %b exp %b", obs, 7'b1010001);
    end
    tick();
    bus.step = 1'b0;
    checks++;
    if (obs !== 7'b0000110) begin
      errors++;
      $display("FAIL up_arrive got %b exp %b", obs, 7'b0000110);
    end
  endtask

  task automatic test_down_3_to_0();
    request(2'd3);
    pulse_steps(16);
    checks++;
    if (obs !== 7'b0000111) begin
      errors++;
      $display("FAIL down_at3 got %b exp %b", obs, 7'b0000111);
    end
    request(2'd0);
    checks++;
    if (obs !== 7'b0110011) begin
      errors++;
      $display("FAIL down_accept got %b exp %b", obs, 7'b0110011);
    end
    pulse_steps(16);
    checks++;
    if (obs !== 7'b0110010) begin
      errors++;
      $display("FAIL down_lvl2 got %b exp %b", obs, 7'b0110010);
    end
    pulse_steps(16);
    checks++;
    if (obs !== 7'b0110001) begin
      errors++;
      $display("FAIL down_lvl1 got %b exp %b", obs, 7'b0110001);
    end
    pulse_steps(16);
    checks++;
    if (obs !== 7'b0000100) begin
      errors++;
      $display("FAIL down_arrive got %b exp %b", obs, 7'b0000100);
    end
  endtask

  task automatic test_same_level();
    request(2'd1);
    pulse_steps(16);
    request(2'd1);
    checks++;
    if (obs !== 7'b0000101) begin
      errors++;
      $display("FAIL same_level got %b exp %b", obs, 7'b0000101);
    end
    pulse_steps(20);
    checks++;
    if (obs !== 7'b0000101) begin
      errors++;
      $display("FAIL idle_step got %b exp %b", obs, 7'b0000101);
    end
  endtask

  task automatic test_timeout();
    request(2'd3);
    bus.step = 1'b1;
    repeat (3) tick();
    bus.step = 1'b0;
    repeat (254) tick();
    checks++;
    if (obs !== 7'b1010001) begin
      errors++;
      $display("FAIL tmo_before got %b exp %b", obs, 7'b1010001);
    end
    tick();
    checks++;
    if (obs !== 7'b0001001) begin
      errors++;
      $display("FAIL tmo_fault got %b exp %b", obs, 7'b0001001);
    end
    pulse_steps(16);
    checks++;
    if (obs !== 7'b0001001) begin
      errors++;
      $display("FAIL fault_step got %b exp %b", obs, 7'b0001001);
    end
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    checks++;
    if (obs !== 7'b0000101) begin
      errors++;
      $display("FAIL fault_clr got %b exp %b", obs, 7'b0000101);
    end
    // step count must restart from zero after the fault
    request(2'd2);
    pulse_steps(13);
    checks++;
    if (obs !== 7'b1010001) begin
      errors++;
      $display("FAIL clr_step13 got %b exp %b", obs, 7'b1010001);
    end
    pulse_steps(3);
    checks++;
    if (obs !== 7'b0000110) begin
      errors++;
      $display("FAIL clr_arrive got %b exp %b", obs, 7'b0000110);
    end
  endtask

  task automatic test_reset_mid_move();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    request(2'd3);
    pulse_steps(20);
    checks++;
    if (obs !== 7'b1010001) begin
      errors++;
      $display("FAIL mid_step20 got %b exp %b", obs, 7'b1010001);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("FAIL mid_async got %b exp %b", obs, 7'b0000000);
    end
    #4;
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 7'b0000100) begin
      errors++;
      $display("FAIL mid_release got %b exp %b", obs, 7'b0000100);
    end
  endtask

`ifdef BLINDS_STOP_EN
  task automatic test_stop();
    request(2'd3);
    pulse_steps(4);
    bus.step = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.stop = 1'b0;
    repeat (3) tick();
    pulse_steps(10);
    checks++;
    if (obs !== 7'b1010000) begin
      errors++;
      $display("FAIL stop_step15 got %b exp %b", obs, 7'b1010000);
    end
    pulse_steps(1);
    checks++;
    if (obs !== 7'b0000101) begin
      errors++;
      $display("FAIL stop_arrive got %b exp %b", obs, 7'b0000101);
    end
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_level = 2'd0;
    bus.step      = 1'b0;
    bus.fault_clr = 1'b0;
`ifdef BLINDS_STOP_EN
    bus.stop      = 1'b0;
`endif
    test_reset();
    test_up_0_to_2();
    test_down_3_to_0();
    test_same_level();
    test_timeout();
    test_reset_mid_move();
`ifdef BLINDS_STOP_EN
    test_stop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blinds_ctrl.md
Name: blinds_ctrl

Overview:
- Sequential position controller for the electric roller blinds. It accepts a requested opening level and drives the motor up or down, counting encoder step pulses.
- It tracks the current level and outputs it as the a/b select code consumed by the blinds output mux: 00 closed, 01 quarter, 10 half, 11 fully open.
- It sits between the user request logic and the motor driver and supplies the select pair to the mux.

Parameters:
- STEPS_PER_LEVEL, 16, encoder step pulses between adjacent levels; legal range 2..255.
- TIMEOUT, 255, clock cycles allowed between step pulses while moving before a fault is raised; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request valid.
- req_level  input  2  requested level, 0..3.
- req_ready  output  1  controller can accept a request.
- step  input  1  one-cycle motor encoder pulse, synchronous to clk.
- fault_clr  input  1  one-cycle pulse that clears a fault.
- motor_up  output  1  drive motor toward open.
- motor_down  output  1  drive motor toward closed.
- a  output  1  current level bit 1.
- b  output  1  current level bit 0.
- busy  output  1  motor is moving.
- fault  output  1  step timeout occurred.

Interface (already decided):
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset: all outputs and state are registered and clear asynchronously when rst_n=0.
  - state=IDLE, level=0 so a=0 and b=0, target=0, step_cnt=0, tmo_cnt=0.
  - motor_up=0, motor_down=0, busy=0, fault=0, req_ready=1 from the first clock after release.
- Registers:
  - level[1:0], target[1:0].
  - step_cnt: $clog2(STEPS_PER_LEVEL) bits.
  - tmo_cnt: $clog2(TIMEOUT+1) bits.
- States: IDLE, UP, DOWN, FAULT.
- req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready.
- IDLE, on accept:
  - req_level>level: target<=req_level, go to UP next cycle.
  - req_level<level: target<=req_level, go to DOWN.
  - req_level==level: no-op, stay IDLE.
- Motor and busy outputs:
  - In UP, motor_up=1, busy=1.
  - In DOWN, motor_down=1, busy=1.
  - motor_up and motor_down are never both 1.
- Step counting in UP or DOWN, on step=1:
  - If step_cnt==STEPS_PER_LEVEL-1: step_cnt<=0 and level<=level+1 (UP) or level-1 (DOWN).
  - Otherwise step_cnt<=step_cnt+1.
- Arrival: when the updated level equals target, return to IDLE in the same update. Motor outputs drop the cycle after the final step, so latency from the last step to motor off is 1 cycle.
- Level saturation: level never wraps. UP at level 3 or DOWN at level 0 is unreachable by construction; if it occurs, the controller returns to IDLE with no level change.
- Timeout:
  - tmo_cnt clears on entry to UP or DOWN and on every step.
  - It increments each moving cycle without a step.
  - When tmo_cnt==TIMEOUT-1 and no step: go to FAULT, motors off, fault=1, busy=0. level and step_cnt are held.
- FAULT:
  - req_ready=0; step is ignored.
  - On fault_clr=1: go to IDLE, fault=0, step_cnt=0. level is kept; the position is then re-trusted at the last completed level.
- step in IDLE is ignored; no level change.
- Requests during UP or DOWN are not accepted (req_ready=0). The requester must hold req_valid.
- Reset mid-move: motors stop immediately (asynchronous) and level returns to 0. The system assumes a re-home to closed.

Optional Feature:
- Macro: BLINDS_STOP_EN
- Defined:
  - Adds input port stop (1 bit).
  - A stop pulse while in UP or DOWN sets target to the next level boundary in the direction of travel: level+1 for UP, level-1 for DOWN. Motion ends there normally.
  - stop in IDLE or FAULT has no effect.
- Undefined:
  - No stop port; motion always completes to the accepted target.

Decomposition:
- Shared package blinds_pkg:
  - level encoding constants LVL_CLOSED=2'd0, LVL_QUARTER=2'd1, LVL_HALF=2'd2, LVL_OPEN=2'd3.
  - State enum typedef (IDLE, UP, DOWN, FAULT).
- Sub-module blinds_step_tracker:
  - Holds step_cnt, tmo_cnt and the level-boundary/timeout detection.
  - Outputs level_tick and timeout.
  - The top-level FSM owns level, target and the motor outputs.

Test Plan:
1. Reset, then request level 2 with STEPS_PER_LEVEL=16 and a step every 4 cycles.
   - motor_up=1 from the cycle after accept.
   - {a,b}=01 after step 16 and =10 after step 32.
   - motor_up=0 one cycle after step 32; req_ready=1.
2. From level 3, request level 0.
   - motor_down=1; levels pass 11→10→01→00 at every 16th step; returns to IDLE.
3. Request equal to the current level (1).
   - No motor activity; state stays IDLE; req_ready stays 1.
4. Move up with no step pulses for 255 cycles.
   - fault=1, motors 0, level unchanged, req_ready=0.
   - fault_clr pulse: fault=0, IDLE.
5. Assert rst_n=0 mid-move at step 20 toward level 3.
   - Outputs clear asynchronously the same cycle; {a,b}=00.
6. With BLINDS_STOP_EN, request 0→3 and pulse stop at step 5.
   - Motion ends at level 1 after step 16; {a,b}=01.
